// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, condition codes, PC-stage state and default widths.
package cpu_pkg;

   localparam int unsigned PC_W_DEF  = 16;
   localparam int unsigned OFF_W_DEF = 9;

   localparam logic [4:0] OP_BRANCH = 5'b00111;
   localparam logic [4:0] OP_JR     = 5'b01000;
   localparam logic [4:0] OP_HLT    = 5'b11111;

   typedef enum logic [2:0] {
      CC_ALWAYS = 3'd0,
      CC_EQ     = 3'd1,
      CC_NE     = 3'd2,
      CC_LT     = 3'd3,
      CC_GE     = 3'd4,
      CC_LTU    = 3'd5,
      CC_GEU    = 3'd6,
      CC_NEVER  = 3'd7
   } cond_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } pc_state_t;

endpackage

// File: rtl/pc_branch_ctrl_branch_target_gen.sv
// Redirect target: sign-extended branch offset added to PC+1, with a jump taking precedence.
module branch_target_gen
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W  = PC_W_DEF,
   parameter int unsigned OFF_W = OFF_W_DEF
) (
   input  logic [OFF_W-1:0] br_offset,
   input  logic [PC_W-1:0]  ex_pc1,
   input  logic             jr_valid,
   input  logic [PC_W-1:0]  jr_target,
   output logic [PC_W-1:0]  target_c
);

   logic [PC_W-1:0] offset_sx;
   logic [PC_W-1:0] br_target;

   // Sign-extend the offset and add modulo 2^PC_W, so wrap is legal both ways.
   always_comb begin
      offset_sx = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
      br_target = ex_pc1 + offset_sx;
      target_c  = jr_valid ? jr_target : br_target;
   end

endmodule

// File: rtl/pc_branch_ctrl.sv
// PC and branch-redirect stage: owns fetch PC, turns taken branches/jumps into a
// redirect plus counted flush, handles stall and HLT.
// Optional: define BRANCH_STATS_EN to add saturating branch taken/total counters.
module pc_branch_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned    PC_W         = PC_W_DEF,
   parameter int unsigned    OFF_W        = OFF_W_DEF,
   parameter int unsigned    FLUSH_CYCLES = 2,
   parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             br_valid,
   input  logic             cond_true,
   input  logic [OFF_W-1:0] br_offset,
   input  logic [PC_W-1:0]  ex_pc1,
   input  logic             jr_valid,
   input  logic [PC_W-1:0]  jr_target,
   input  logic             halt_req,
`ifdef BRANCH_STATS_EN
   output logic [15:0]      br_taken_cnt,
   output logic [15:0]      br_total_cnt,
`endif
   output logic [PC_W-1:0]  pc,
   output logic [PC_W-1:0]  pc_plus1,
   output logic             fetch_valid,
   output logic             flush,
   output logic             halted
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

   pc_state_t       state, state_nx;
   logic [2:0]      flush_cnt, cnt_nx;
   logic [PC_W-1:0] pc_nx;
   logic            fv_nx, flush_nx, halted_nx;
   logic            redirect_c;
   logic [PC_W-1:0] target_c;

   branch_target_gen #(
      .PC_W  (PC_W),
      .OFF_W (OFF_W)
   ) u_tgt (
      .br_offset (br_offset),
      .ex_pc1    (ex_pc1),
      .jr_valid  (jr_valid),
      .jr_target (jr_target),
      .target_c  (target_c)
   );

   assign redirect_c = jr_valid | (br_valid & cond_true);
   assign pc_plus1   = pc + PC_W'(1);

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         flush_cnt   <= 3'd0;
         pc          <= RESET_VECTOR;
         fetch_valid <= 1'b0;
         flush       <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state       <= state_nx;
         flush_cnt   <= cnt_nx;
         pc          <= pc_nx;
         fetch_valid <= fv_nx;
         flush       <= flush_nx;
         halted      <= halted_nx;
      end
   end

   // Next state: halt > jump > taken branch > sequential; stall holds everything.
   always_comb begin
      state_nx  = state;
      cnt_nx    = flush_cnt;
      pc_nx     = pc;
      fv_nx     = fetch_valid;
      halted_nx = halted;
      if (!stall) begin
         case (state)
            ST_HALT: begin
            end
            default: begin
               if (!fetch_valid) begin
                  // First edge out of reset starts fetch without advancing pc.
                  fv_nx = 1'b1;
               end else if (halt_req) begin
                  state_nx  = ST_HALT;
                  halted_nx = 1'b1;
                  fv_nx     = 1'b0;
                  cnt_nx    = 3'd0;
               end else if (redirect_c) begin
                  pc_nx    = target_c;
                  cnt_nx   = FLUSH_LOAD;
                  state_nx = ST_FLUSH;
               end else begin
                  pc_nx = pc + PC_W'(1);
                  if (state == ST_FLUSH) begin
                     cnt_nx = flush_cnt - 3'd1;
                     if (cnt_nx == 3'd0) begin
                        state_nx = ST_RUN;
                     end
                  end
               end
            end
         endcase
      end
      flush_nx = (cnt_nx != 3'd0);
   end

`ifdef BRANCH_STATS_EN
   logic stat_en_c;

   assign stat_en_c = !stall && fetch_valid && (state != ST_HALT) && br_valid;

   // Saturating branch counters, frozen while halted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_total_cnt <= 16'd0;
         br_taken_cnt <= 16'd0;
      end else if (stat_en_c) begin
         if (br_total_cnt != 16'hFFFF) begin
            br_total_cnt <= br_total_cnt + 16'd1;
         end
         if (cond_true && (br_taken_cnt != 16'hFFFF)) begin
            br_taken_cnt <= br_taken_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Scoreboarded bench for pc_branch_ctrl: each step pushes its expected outputs
// when driven and the owning test pops and compares them after the edge.
module tb_pc_branch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, br_valid, cond_true, jr_valid, halt_req;
   logic [8:0]  br_offset;
   logic [15:0] ex_pc1, jr_target;
   logic [15:0] pc, pc_plus1;
   logic        fetch_valid, flush, halted;
`ifdef BRANCH_STATS_EN
   logic [15:0] br_taken_cnt, br_total_cnt;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        st, bv, ct, jv, hr;
      logic [8:0]  off;
      logic [15:0] epc, jt;
      logic [15:0] xpc;
      logic        xfv, xfl, xhl;
   } step_t;

   typedef struct {
      logic [15:0] pc;
      logic        fv, fl, hl;
   } exp_t;

   exp_t exp_q[$];

   pc_branch_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .br_valid    (br_valid),
      .cond_true   (cond_true),
      .br_offset   (br_offset),
      .ex_pc1      (ex_pc1),
      .jr_valid    (jr_valid),
      .jr_target   (jr_target),
      .halt_req    (halt_req),
`ifdef BRANCH_STATS_EN
      .br_taken_cnt(br_taken_cnt),
      .br_total_cnt(br_total_cnt),
`endif
      .pc          (pc),
      .pc_plus1    (pc_plus1),
      .fetch_valid (fetch_valid),
      .flush       (flush),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic step_t mk(logic st, logic bv, logic ct, logic [8:0] off, logic [15:0] epc,
                                logic jv, logic [15:0] jt, logic hr,
                                logic [15:0] xpc, logic xfv, logic xfl, logic xhl);
      step_t s;
      s.st = st; s.bv = bv; s.ct = ct; s.off = off; s.epc = epc;
      s.jv = jv; s.jt = jt; s.hr = hr;
      s.xpc = xpc; s.xfv = xfv; s.xfl = xfl; s.xhl = xhl;
      return s;
   endfunction

   function automatic step_t idle(logic [15:0] xpc, logic xfl);
      return mk(0, 0, 0, 9'd0, 16'd0, 0, 16'd0, 0, xpc, 1, xfl, 0);
   endfunction

   task automatic apply(input step_t s);
      exp_t e;
      stall = s.st; br_valid = s.bv; cond_true = s.ct; br_offset = s.off;
      ex_pc1 = s.epc; jr_valid = s.jv; jr_target = s.jt; halt_req = s.hr;
      e.pc = s.xpc; e.fv = s.xfv; e.fl = s.xfl; e.hl = s.xhl;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      step_t s[$];
      exp_t  e;
      rst_n = 1'b0;
      apply(mk(0, 0, 0, 9'd0, 16'd0, 0, 16'd0, 0, 16'h0000, 0, 0, 0));
      tick();
      e = exp_q.pop_front();
      total++;
      if ({pc, fetch_valid, flush, halted} !== {e.pc, e.fv, e.fl, e.hl}) begin
         bad++;
         $display("FAIL reset_state: pc=%h fv=%b fl=%b hl=%b want pc=%h fv=%b fl=%b hl=%b",
                  pc, fetch_valid, flush, halted, e.pc, e.fv, e.fl, e.hl);
      end
      rst_n = 1'b1;
      s.push_back(idle(16'h0000, 0));
      s.push_back(idle(16'h0001, 0));
      s.push_back(idle(16'h0002, 0));
      s.push_back(idle(16'h0003, 0));
      foreach (s[i]) begin
         apply(s[i]);
         tick();
         e = exp_q.pop_front();
         total++;
         if ({pc, pc_plus1, fetch_valid, flush, halted} !== {e.pc, e.pc + 16'd1, e.fv, e.fl, e.hl}) begin
            bad++;
            $display("FAIL startup step %0d: pc=%h pc1=%h fv=%b fl=%b hl=%b want pc=%h fv=%b fl=%b hl=%b",
                     i, pc, pc_plus1, fetch_valid, flush, halted, e.pc, e.fv, e.fl, e.hl);
         end
      end
   endtask

   task automatic test_branch();
      step_t s[$];
      exp_t  e;
      // Taken backward branch from pc=3: 0x10 + (-4) = 0x0C, two flush cycles.
      s.push_back(mk(0, 1, 1, 9'h1FC, 16'h0010, 0, 16'd0, 0, 16'h000C, 1, 1, 0));
      s.push_back(idle(16'h000D, 1));
      s.push_back(idle(16'h000E, 0));
      s.push_back(idle(16'h000F, 0));
      // Jump to 0x1E, settle, then a not-taken branch at 0x20.
      s.push_back(mk(0, 0, 0, 9'd0, 16'd0, 1, 16'h001E, 0, 16'h001E, 1, 1, 0));
      s.push_back(idle(16'h001F, 1));
      s.push_back(idle(16'h0020, 0));
      s.push_back(mk(0, 1, 0, 9'h1FC, 16'h0021, 0, 16'd0, 0, 16'h0021, 1, 0, 0));
      s.push_back(idle(16'h0022, 0));
      foreach (s[i]) begin
         apply(s[i]);
         tick();
         e = exp_q.pop_front();
         total++;
         if ({pc, pc_plus1, fetch_valid, flush, halted} !== {e.pc, e.pc + 16'd1, e.fv, e.fl, e.hl}) begin
            bad++;
            $display("FAIL branch step %0d: pc=%h pc1=%h fv=%b fl=%b hl=%b want pc=%h fv=%b fl=%b hl=%b",
                     i, pc, pc_plus1, fetch_valid, flush, halted, e.pc, e.fv, e.fl, e.hl);
         end
      end
   endtask

   task automatic test_wrap();
      step_t s[$];
      exp_t  e;
      s.push_back(mk(0, 1, 1, 9'h005, 16'hFFFE, 0, 16'd0, 0, 16'h0003, 1, 1, 0));
      s.push_back(idle(16'h0004, 1));
      s.push_back(idle(16'h0005, 0));
      s.push_back(mk(0, 0, 0, 9'd0, 16'd0, 1, 16'hFFFD, 0, 16'hFFFD, 1, 1, 0));
      s.push_back(idle(16'hFFFE, 1));
      s.push_back(idle(16'hFFFF, 0));
      s.push_back(idle(16'h0000, 0));
      // Jump beats branch; a redirect inside FLUSH reloads the count.
      s.push_back(mk(0, 1, 1, 9'h000, 16'h0010, 1, 16'h0050, 0, 16'h0050, 1, 1, 0));
      s.push_back(mk(0, 1, 1, 9'h004, 16'h0060, 0, 16'd0, 0, 16'h0064, 1, 1, 0));
      s.push_back(idle(16'h0065, 1));
      s.push_back(idle(16'h0066, 0));
      foreach (s[i]) begin
         apply(s[i]);
         tick();
         e = exp_q.pop_front();
         total++;
         if ({pc, pc_plus1, fetch_valid, flush, halted} !== {e.pc, e.pc + 16'd1, e.fv, e.fl, e.hl}) begin
            bad++;
            $display("FAIL wrap step %0d: pc=%h pc1=%h fv=%b fl=%b hl=%b want pc=%h fv=%b fl=%b hl=%b",
                     i, pc, pc_plus1, fetch_valid, flush, halted, e.pc, e.fv, e.fl, e.hl);
         end
      end
   endtask

   task automatic test_stall();
      step_t s[$];
      exp_t  e;
      s.push_back(mk(0, 0, 0, 9'd0, 16'd0, 1, 16'h0040, 0, 16'h0040, 1, 1, 0));
      s.push_back(idle(16'h0041, 1));
      // Stalled with live EX inputs: all of them must be ignored.
      s.push_back(mk(1, 0, 0, 9'd0, 16'd0, 1, 16'h0099, 0, 16'h0041, 1, 1, 0));
      s.push_back(mk(1, 1, 1, 9'h010, 16'h0200, 0, 16'd0, 0, 16'h0041, 1, 1, 0));
      s.push_back(mk(1, 0, 0, 9'd0, 16'd0, 0, 16'd0, 1, 16'h0041, 1, 1, 0));
      s.push_back(idle(16'h0042, 0));
      s.push_back(idle(16'h0043, 0));
      foreach (s[i]) begin
         apply(s[i]);
         tick();
         e = exp_q.pop_front();
         total++;
         if ({pc, pc_plus1, fetch_valid, flush, halted} !== {e.pc, e.pc + 16'd1, e.fv, e.fl, e.hl}) begin
            bad++;
            $display("FAIL stall step %0d: pc=%h pc1=%h fv=%b fl=%b hl=%b want pc=%h fv=%b fl=%b hl=%b",
                     i, pc, pc_plus1, fetch_valid, flush, halted, e.pc, e.fv, e.fl, e.hl);
         end
      end
   endtask

   task automatic test_halt();
      step_t s[$];
      exp_t  e;
      s.push_back(mk(0, 0, 0, 9'd0, 16'd0, 1, 16'h0100, 1, 16'h0043, 0, 0, 1));
      s.push_back(mk(0, 1, 1, 9'h004, 16'h0070, 0, 16'd0, 0, 16'h0043, 0, 0, 1));
      s.push_back(mk(0, 0, 0, 9'd0, 16'd0, 1, 16'h0200, 0, 16'h0043, 0, 0, 1));
      foreach (s[i]) begin
         apply(s[i]);
         tick();
         e = exp_q.pop_front();
         total++;
         if ({pc, fetch_valid, flush, halted} !== {e.pc, e.fv, e.fl, e.hl}) begin
            bad++;
            $display("FAIL halt step %0d: pc=%h fv=%b fl=%b hl=%b want pc=%h fv=%b fl=%b hl=%b",
                     i, pc, fetch_valid, flush, halted, e.pc, e.fv, e.fl, e.hl);
         end
      end
      // Asynchronous reset out of HALT, checked before any clock edge.
      #2;
      rst_n = 1'b0;
      apply(mk(0, 0, 0, 9'd0, 16'd0, 0, 16'd0, 0, 16'h0000, 0, 0, 0));
      #1;
      e = exp_q.pop_front();
      total++;
      if ({pc, fetch_valid, flush, halted} !== {e.pc, e.fv, e.fl, e.hl}) begin
         bad++;
         $display("FAIL halt_reset: pc=%h fv=%b fl=%b hl=%b want pc=%h fv=%b fl=%b hl=%b",
                  pc, fetch_valid, flush, halted, e.pc, e.fv, e.fl, e.hl);
      end
      tick();
      rst_n = 1'b1;
      apply(idle(16'h0000, 0));
      tick();
      e = exp_q.pop_front();
      total++;
      if ({pc, fetch_valid, flush, halted} !== {e.pc, e.fv, e.fl, e.hl}) begin
         bad++;
         $display("FAIL restart: pc=%h fv=%b fl=%b hl=%b want pc=%h fv=%b fl=%b hl=%b",
                  pc, fetch_valid, flush, halted, e.pc, e.fv, e.fl, e.hl);
      end
   endtask

   task automatic test_reset_mid_flush();
      exp_t e;
      apply(mk(0, 0, 0, 9'd0, 16'd0, 1, 16'h0300, 0, 16'h0300, 1, 1, 0));
      tick();
      e = exp_q.pop_front();
      total++;
      if ({pc, flush} !== {e.pc, e.fl}) begin
         bad++;
         $display("FAIL mid_flush_setup: pc=%h fl=%b want pc=%h fl=%b", pc, flush, e.pc, e.fl);
      end
      #2;
      rst_n = 1'b0;
      apply(idle(16'h0000, 0));
      #1;
      e = exp_q.pop_front();
      total++;
      if ({pc, fetch_valid, flush, halted} !== {e.pc, 1'b0, e.fl, e.hl}) begin
         bad++;
         $display("FAIL mid_flush_reset: pc=%h fv=%b fl=%b hl=%b want pc=%h fv=0 fl=%b hl=%b",
                  pc, fetch_valid, flush, halted, e.pc, e.fl, e.hl);
      end
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 0; br_valid = 0; cond_true = 0; jr_valid = 0; halt_req = 0;
      br_offset = '0; ex_pc1 = '0; jr_target = '0;
      #3;
      test_reset();
      test_branch();
      test_wrap();
      test_stall();
      test_halt();
      test_reset_mid_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time exceeded limit");
      $fatal(1, "timeout");
   end

endmodule
